// File: rtl/tenthirty_pkg.sv
// Shared types and helpers for the tenthirty card game: deck geometry,
// dealer FSM states and the divider-free rank lookup.
`timescale 1ns/1ps
package tenthirty_pkg;

    localparam int          DECK_SIZE = 52;
    localparam int          RANKS     = 13;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROBE   = 2'd1,
        SHUFFLE = 2'd2
    } dealer_state_t;

    // Rank 1..RANKS of a card index. Three conditional subtractions cover any
    // deck of up to 4*RANKS cards without a divider.
    function automatic logic [3:0] rank_of(input logic [7:0] idx, input int ranks = RANKS);
        logic [7:0] r;
        r = idx;
        for (int i = 0; i < 3; i++) begin
            if (r >= 8'(ranks)) begin
                r = r - 8'(ranks);
            end
        end
        return 4'(r + 8'd1);
    endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left with
// feedback into bit 0. Also usable by the game FSM as a random source.
`timescale 1ns/1ps
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] q_reg;
    logic [15:0] q_next;
    logic        feedback;

    always_comb begin
        feedback = q_reg[15] ^ q_reg[13] ^ q_reg[12] ^ q_reg[10];
        q_next   = {q_reg[14:0], feedback};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= SEED;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/card_dealer.sv
// Card dealer for tenthirty: each pip deals one card without replacement,
// chosen by an LFSR candidate plus linear probing over a used-card bitmap.
// Optional build macro CARD_DEALER_RESHUFFLE_EN: a pip on an empty deck
// reshuffles automatically instead of being ignored.
`timescale 1ns/1ps
module card_dealer #(
    parameter int          DECK_SIZE = tenthirty_pkg::DECK_SIZE,
    parameter int          RANKS     = tenthirty_pkg::RANKS,
    parameter logic [15:0] LFSR_SEED = tenthirty_pkg::LFSR_SEED,
    localparam int         IDX_W     = $clog2(DECK_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pip,
    input  logic             new_deck,
    output logic [3:0]       number,
    output logic             num_valid,
    output logic             busy,
    output logic             deck_empty,
    output logic [IDX_W-1:0] cards_left
);

    import tenthirty_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DECK_SIZE - 1);
    localparam logic [IDX_W-1:0] FULL_COUNT = IDX_W'(DECK_SIZE);

    logic [15:0]          lfsr_q;
    logic                 lfsr_unused;
    logic [IDX_W-1:0]     cand_raw;
    logic [IDX_W-1:0]     cand;

    dealer_state_t        state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DECK_SIZE-1:0] used_reg, used_next;
    logic [3:0]           number_reg, number_next;
    logic                 num_valid_reg, num_valid_next;
    logic [IDX_W-1:0]     cards_left_reg, cards_left_next;
    logic                 deck_empty_reg, deck_empty_next;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    // Only the low IDX_W bits pick a card; the rest just keep the sequence long.
    assign lfsr_unused = ^lfsr_q[15:IDX_W];
    assign cand_raw    = lfsr_q[IDX_W-1:0];

    // DECK_SIZE >= 2**(IDX_W-1), so a single subtract folds the raw value into range.
    always_comb begin
        cand = cand_raw;
        if (cand_raw > LAST_IDX) begin
            cand = cand_raw - FULL_COUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        used_next       = used_reg;
        number_next     = number_reg;
        num_valid_next  = 1'b0;
        cards_left_next = cards_left_reg;
        deck_empty_next = deck_empty_reg;

        if (new_deck) begin
            // Aborts any draw in flight; the last dealt number stays visible.
            state_next      = IDLE;
            used_next       = '0;
            cards_left_next = FULL_COUNT;
            deck_empty_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pip && !deck_empty_reg) begin
                        idx_next   = cand;
                        state_next = PROBE;
                    end
`ifdef CARD_DEALER_RESHUFFLE_EN
                    else if (pip && deck_empty_reg) begin
                        used_next       = '0;
                        cards_left_next = FULL_COUNT;
                        deck_empty_next = 1'b0;
                        state_next      = SHUFFLE;
                    end
`endif
                end
                PROBE: begin
                    if (!used_reg[idx_reg]) begin
                        used_next[idx_reg] = 1'b1;
                        number_next        = rank_of(8'(idx_reg), RANKS);
                        num_valid_next     = 1'b1;
                        cards_left_next    = cards_left_reg - IDX_W'(1);
                        deck_empty_next    = (cards_left_reg == IDX_W'(1));
                        state_next         = IDLE;
                    end else begin
                        // Collision: walk to the next slot, wrapping at the deck end.
                        idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
                    end
                end
`ifdef CARD_DEALER_RESHUFFLE_EN
                SHUFFLE: begin
                    idx_next   = cand;
                    state_next = PROBE;
                end
`endif
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg        <= '0;
            used_reg       <= '0;
            number_reg     <= 4'd0;
            num_valid_reg  <= 1'b0;
            cards_left_reg <= FULL_COUNT;
            deck_empty_reg <= 1'b0;
        end else begin
            idx_reg        <= idx_next;
            used_reg       <= used_next;
            number_reg     <= number_next;
            num_valid_reg  <= num_valid_next;
            cards_left_reg <= cards_left_next;
            deck_empty_reg <= deck_empty_next;
        end
    end

    assign number     = number_reg;
    assign num_valid  = num_valid_reg;
    assign busy       = (state_reg != IDLE);
    assign deck_empty = deck_empty_reg;
    assign cards_left = cards_left_reg;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: predicts every deal with its own LFSR and
// deck model and checks latency, rank, counters and the corner cases.
`timescale 1ns/1ps
module tb_card_dealer;

    localparam int DECK = 52;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pip = 1'b0;
    logic       new_deck = 1'b0;
    logic [3:0] number;
    logic       num_valid;
    logic       busy;
    logic       deck_empty;
    logic [5:0] cards_left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    card_dealer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pip        (pip),
        .new_deck   (new_deck),
        .number     (number),
        .num_valid  (num_valid),
        .busy       (busy),
        .deck_empty (deck_empty),
        .cards_left (cards_left)
    );

    // Reference LFSR and deck state.
    logic [15:0] m_lfsr;
    bit          m_used [DECK];
    int          m_left;
    int          rank_cnt [14];
    int          deals_seen;
    int          last_rank;
    int          last_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic int model_cand();
        int c;
        c = int'(m_lfsr[5:0]);
        if (c >= DECK) c -= DECK;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DECK; i++) m_used[i] = 1'b0;
        for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
        m_left = DECK;
        deals_seen = 0;
    endtask

    // One pip, checked against the model's predicted slot and latency.
    task automatic deal(input string tag);
        int idx, coll, lat, exp_rank;
        idx  = model_cand();
        coll = 0;
        while (m_used[idx] && coll < DECK) begin
            idx = (idx == DECK - 1) ? 0 : idx + 1;
            coll++;
        end
        exp_rank = (idx % 13) + 1;
        pip = 1'b1;
        tick();
        pip = 1'b0;
        lat = 1;
        while (!num_valid && lat < DECK + 10) begin
            tick();
            lat++;
        end
        checks++;
        if (!num_valid) begin
            errors++;
            $display("FAIL %s timeout: no num_valid within %0d cycles", tag, lat);
        end else begin
            deals_seen++;
            if (int'(number) < 14) rank_cnt[number]++;
            m_used[idx] = 1'b1;
            m_left--;
            last_rank = exp_rank;
            last_idx  = idx;
            $display("deal %s idx=%0d rank=%0d lat=%0d left=%0d", tag, idx, number, lat, cards_left);
            checks++;
            if (lat != 2 + coll) begin
                errors++;
                $display("FAIL %s latency got=%0d exp=%0d", tag, lat, 2 + coll);
            end
            checks++;
            if (number !== 4'(exp_rank)) begin
                errors++;
                $display("FAIL %s number got=%0d exp=%0d", tag, number, exp_rank);
            end
            checks++;
            if (cards_left !== 6'(m_left)) begin
                errors++;
                $display("FAIL %s cards_left got=%0d exp=%0d", tag, cards_left, m_left);
            end
            checks++;
            if (deck_empty !== (m_left == 0)) begin
                errors++;
                $display("FAIL %s deck_empty got=%0b exp=%0b", tag, deck_empty, m_left == 0);
            end
            tick();
            checks++;
            if (num_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s pulse_width num_valid got=%0b exp=0", tag, num_valid);
            end
        end
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic wait_cand(input int target, output bit ok);
        int n;
        n = 0;
        while (model_cand() != target && n < 4000) begin
            tick();
            n++;
        end
        ok = (model_cand() == target);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_cand timeout got_cycles=%0d exp_target=%0d", n, target);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (number !== 4'd0)     begin errors++; $display("FAIL reset number got=%0d exp=0", number); end
        checks++; if (num_valid !== 1'b0)  begin errors++; $display("FAIL reset num_valid got=%0b exp=0", num_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy got=%0b exp=0", busy); end
        checks++; if (deck_empty !== 1'b0) begin errors++; $display("FAIL reset deck_empty got=%0b exp=0", deck_empty); end
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL reset cards_left got=%0d exp=52", cards_left); end
    endtask

    // Seed 0xACE1: low six bits are 33, so the first card is rank 33%13+1 = 8.
    task automatic test_first_deal();
        model_clear();
        rst_n = 1'b1;
        deal("first");
        checks++;
        if (number !== 4'd8) begin
            errors++;
            $display("FAIL first_rank got=%0d exp=8", number);
        end
    endtask

    task automatic test_full_deck(input string tag);
        int guard;
        guard = 0;
        while (m_left > 0 && guard < DECK + 2) begin
            deal(tag);
            guard++;
        end
        checks++; if (deck_empty !== 1'b1)  begin errors++; $display("FAIL %s_empty deck_empty got=%0b exp=1", tag, deck_empty); end
        checks++; if (cards_left !== 6'd0)  begin errors++; $display("FAIL %s_empty cards_left got=%0d exp=0", tag, cards_left); end
        checks++; if (deals_seen != DECK)   begin errors++; $display("FAIL %s_count deals got=%0d exp=%0d", tag, deals_seen, DECK); end
        for (int r = 1; r <= 13; r++) begin
            checks++;
            if (rank_cnt[r] != 4) begin
                errors++;
                $display("FAIL %s_rank%0d count got=%0d exp=4", tag, r, rank_cnt[r]);
            end
        end
    endtask

    task automatic test_empty_pip();
`ifdef CARD_DEALER_RESHUFFLE_EN
        int idx;
        pip = 1'b1;
        tick();
        pip = 1'b0;
        checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL empty_shuffle busy got=%0b exp=1", busy); end
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL empty_shuffle cards_left got=%0d exp=52", cards_left); end
        idx = model_cand();
        tick();
        checks++; if (num_valid !== 1'b0)   begin errors++; $display("FAIL empty_early num_valid got=%0b exp=0", num_valid); end
        tick();
        checks++; if (num_valid !== 1'b1)   begin errors++; $display("FAIL empty_lat3 num_valid got=%0b exp=1", num_valid); end
        checks++; if (number !== 4'((idx % 13) + 1)) begin errors++; $display("FAIL empty_rank got=%0d exp=%0d", number, (idx % 13) + 1); end
        checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL empty_left got=%0d exp=51", cards_left); end
        $display("deal reshuffle idx=%0d rank=%0d left=%0d", idx, number, cards_left);
        model_clear();
        m_used[idx] = 1'b1;
        m_left = DECK - 1;
        last_rank = (idx % 13) + 1;
        tick();
`else
        int bad;
        bad = 0;
        pip = 1'b1;
        tick();
        pip = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (num_valid || busy) bad++;
            tick();
        end
        $display("empty pip ignored: bad_cycles=%0d number=%0d", bad, number);
        checks++; if (bad != 0)                 begin errors++; $display("FAIL empty_ignored bad_cycles got=%0d exp=0", bad); end
        checks++; if (number !== 4'(last_rank)) begin errors++; $display("FAIL empty_hold number got=%0d exp=%0d", number, last_rank); end
        checks++; if (cards_left !== 6'd0)      begin errors++; $display("FAIL empty_left got=%0d exp=0", cards_left); end
`endif
    endtask

    task automatic do_new_deck(input string tag);
        new_deck = 1'b1;
        tick();
        new_deck = 1'b0;
        model_clear();
        $display("new_deck %s left=%0d empty=%0b", tag, cards_left, deck_empty);
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL %s cards_left got=%0d exp=52", tag, cards_left); end
        checks++; if (deck_empty !== 1'b0)  begin errors++; $display("FAIL %s deck_empty got=%0b exp=0", tag, deck_empty); end
    endtask

    // Lands a card on slot 51, then aims at 51 again so the probe wraps to 0.
    task automatic test_collision();
        bit ok;
        do_new_deck("coll_refill");
        wait_cand(51, ok);
        if (ok) deal("c51");
        wait_cand(51, ok);
        if (ok) begin
            deal("wrap");
            checks++; if (number !== 4'd1) begin errors++; $display("FAIL wrap_rank got=%0d exp=1", number); end
        end
        wait_cand(0, ok);
        if (ok) begin
            deal("c0");
            checks++; if (number !== 4'd2) begin errors++; $display("FAIL c0_rank got=%0d exp=2", number); end
        end
    endtask

    task automatic test_new_deck_with_pip();
        int pulses;
        pulses = 0;
        pip = 1'b1;
        new_deck = 1'b1;
        tick();
        pip = 1'b0;
        new_deck = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            if (num_valid) pulses++;
            tick();
        end
        $display("pip+new_deck pulses=%0d left=%0d empty=%0b", pulses, cards_left, deck_empty);
        checks++; if (pulses != 0)              begin errors++; $display("FAIL nd_pip pulses got=%0d exp=0", pulses); end
        checks++; if (cards_left !== 6'd52)     begin errors++; $display("FAIL nd_pip cards_left got=%0d exp=52", cards_left); end
        checks++; if (deck_empty !== 1'b0)      begin errors++; $display("FAIL nd_pip deck_empty got=%0b exp=0", deck_empty); end
        checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL nd_pip busy got=%0b exp=0", busy); end
        checks++; if (number !== 4'(last_rank)) begin errors++; $display("FAIL nd_pip number got=%0d exp=%0d", number, last_rank); end
    endtask

    task automatic test_pip_while_busy();
        int idx, exp_rank, pulses, got;
        idx = model_cand();
        exp_rank = (idx % 13) + 1;
        pulses = 0;
        got = -1;
        pip = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag got=%0b exp=1", busy); end
        tick();
        pip = 1'b0;
        for (int i = 0; i < DECK + 6; i++) begin
            if (num_valid) begin
                pulses++;
                got = int'(number);
            end
            tick();
        end
        m_used[idx] = 1'b1;
        m_left--;
        last_rank = exp_rank;
        $display("busy pip pulses=%0d rank=%0d left=%0d", pulses, got, cards_left);
        checks++; if (pulses != 1)           begin errors++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
        checks++; if (got != exp_rank)       begin errors++; $display("FAIL busy_rank got=%0d exp=%0d", got, exp_rank); end
        checks++; if (cards_left !== 6'd51)  begin errors++; $display("FAIL busy_left got=%0d exp=51", cards_left); end
    endtask

    task automatic test_reset_mid_probe();
        pip = 1'b1;
        tick();
        pip = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstp_busy_before got=%0b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-probe number=%0d valid=%0b busy=%0b left=%0d", number, num_valid, busy, cards_left);
        checks++; if (number !== 4'd0)      begin errors++; $display("FAIL rstp number got=%0d exp=0", number); end
        checks++; if (num_valid !== 1'b0)   begin errors++; $display("FAIL rstp num_valid got=%0b exp=0", num_valid); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rstp busy got=%0b exp=0", busy); end
        checks++; if (deck_empty !== 1'b0)  begin errors++; $display("FAIL rstp deck_empty got=%0b exp=0", deck_empty); end
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL rstp cards_left got=%0d exp=52", cards_left); end
        repeat (2) tick();
        model_clear();
        rst_n = 1'b1;
        test_full_deck("rerun");
    endtask

    initial begin
        last_rank = 0;
        last_idx = 0;
        model_clear();
        test_reset();
        test_first_deal();
        test_full_deck("deck");
        test_empty_pip();
        test_collision();
        test_new_deck_with_pip();
        test_pip_while_busy();
        test_reset_mid_probe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
